fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; port names are clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 instr_mem_data  input  32  instruction word read combinationally from instruction memory at pc_fetch.
REQ-005 BrTaken  input  1  decode-stage branch decision for the instruction currently in instruction_fetchOut.
REQ-006 UncondBr  input  1  1 = B (imm26 at [25:0]); 0 = conditional/CBZ (imm19 at [23:5]).
REQ-007 stall  input  1  load-use hazard hold request from the hazard unit.
REQ-008 pc_fetch  output  64  current PC, driven to instruction memory address.
REQ-009 instruction_fetchOut  output  32  IF/ID registered instruction, consumed by decode control.
REQ-010 pc_fetchOut  output  64  IF/ID registered PC of instruction_fetchOut.
REQ-011 valid_fetchOut  output  1  1 = instruction_fetchOut is a real fetched instruction; 0 = reset bubble.

Function
REQ-012 SHALL hold a 64-bit PC register and a 32+64+1-bit IF/ID register, all updated only on the rising clk.
REQ-013 Fetch latency SHALL be one cycle: the word at pc_fetch in cycle N appears on instruction_fetchOut in cycle N+1, with pc_fetchOut = that PC.
REQ-014 Branch offset SHALL be sign-extended to 64 bits then shifted left 2: UncondBr=1 uses instruction_fetchOut[25:0], UncondBr=0 uses instruction_fetchOut[23:5].
REQ-015 Branch target SHALL be pc_fetchOut + shifted offset, 64-bit modular (wrap-around, no overflow flag).
REQ-016 Next PC SHALL be target when BrTaken=1, else pc_fetch + 4 (64-bit modular).
REQ-017 Branches SHALL use one delay slot: the instruction fetched in the cycle BrTaken is asserted is kept and enters IF/ID normally; nothing is flushed.
REQ-018 When stall=1, PC and IF/ID register (including valid) SHALL hold their values; BrTaken is ignored that cycle and re-evaluated next cycle from the held instruction.
REQ-019 When stall=1 and BrTaken=1 together, stall SHALL win; the redirect occurs on the first non-stalled cycle.
REQ-020 BrTaken and UncondBr SHALL only be honoured when valid_fetchOut=1; with valid_fetchOut=0, next PC is pc_fetch + 4.
REQ-021 The block SHALL contain no combinational path from instr_mem_data to any output.

Reset
REQ-022 On reset: pc_fetch = 64'h0, instruction_fetchOut = NOP (32'hD503201F), pc_fetchOut = 64'h0, valid_fetchOut = 0.
REQ-023 Reset SHALL override stall and BrTaken in the same cycle.
REQ-024 Reset asserted mid-operation SHALL take effect at the next rising clk; any pending branch or stall is discarded.
REQ-025 The first rising clk after reset deassertion SHALL load instruction 0 into IF/ID with valid_fetchOut = 1 and set pc_fetch = 4.

Structure
REQ-026 A shared package SHALL hold: NOP encoding, PC width (64), instruction width (32), PC increment (4), and imm26/imm19 field bit positions.
REQ-027 Target computation (sign-extend, shift, add) SHALL be a sub-module named branch_target_calc; everything else stays in fetch_stage.

Verification
REQ-028 Reset then sequential fetch: imem[0..3] = distinct words, no stall/branch -> pc_fetch 0,4,8,12; instruction_fetchOut trails by one cycle; valid_fetchOut = 1 from the first post-reset edge.
REQ-029 Unconditional B: instruction_fetchOut = B imm26=+3 at pc_fetchOut=0x10, BrTaken=1, UncondBr=1 -> the delay-slot word at 0x14 enters IF/ID and the next pc_fetch = 0x1C.
REQ-030 Backward conditional: imm19 = -2 at pc_fetchOut=0x40, BrTaken=1, UncondBr=0 -> next pc_fetch = 0x38.
REQ-031 Stall two cycles with BrTaken=1 -> PC and IF/ID are frozen for both cycles; the redirect to the target occurs on the third cycle.
REQ-032 Wrap: pc_fetch = 64'hFFFF_FFFF_FFFF_FFFC with no branch -> next pc_fetch = 0.
REQ-033 Reset asserted during a stall with BrTaken=1 -> the next edge gives pc_fetch = 0, instruction_fetchOut = NOP and valid_fetchOut = 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Field positions describe where branch immediates live inside an instruction word.
package fetch_stage_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    PC_INC = 64'd4;
  localparam logic [INSTR_W-1:0] NOP    = 32'hD503201F;

  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
  localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;
  localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_branch_target_calc.sv
// Branch target: sign-extend the selected immediate, scale to a byte offset
// and add it to the PC of the branch instruction (64-bit wrap-around).
module branch_target_calc
  import fetch_stage_pkg::*;
(
  input  logic [IMM26_MSB:0] imm_field,
  input  logic [PC_W-1:0]    pc,
  input  logic               uncond_br,
  output logic [PC_W-1:0]    target
);

  logic [PC_W-1:0] offset;

  always_comb begin
    offset = '0;
    if (uncond_br)
      offset = {{(PC_W-IMM26_W){imm_field[IMM26_MSB]}}, imm_field[IMM26_MSB:IMM26_LSB]};
    else
      offset = {{(PC_W-IMM19_W){imm_field[IMM19_MSB]}}, imm_field[IMM19_MSB:IMM19_LSB]};
  end

  assign target = pc + (offset << 2);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register, with a
// single branch delay slot and load-use stall hold.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_mem_data,
  input  logic               BrTaken,
  input  logic               UncondBr,
  input  logic               stall,
  output logic [PC_W-1:0]    pc_fetch,
  output logic [INSTR_W-1:0] instruction_fetchOut,
  output logic [PC_W-1:0]    pc_fetchOut,
  output logic               valid_fetchOut
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] target;
  ifid_t           ifid_q;

  branch_target_calc u_target (
    .imm_field (ifid_q.instr[IMM26_MSB:0]),
    .pc        (ifid_q.pc),
    .uncond_br (UncondBr),
    .target    (target)
  );

  // Branch decisions only count for a real instruction, never the reset bubble.
  always_comb begin
    next_pc = pc_q + PC_INC;
    if (ifid_q.valid && BrTaken)
      next_pc = target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      ifid_q <= '{instr: NOP, pc: '0, valid: 1'b0};
    end else if (!stall) begin
      pc_q   <= next_pc;
      ifid_q <= '{instr: instr_mem_data, pc: pc_q, valid: 1'b1};
    end
  end

  assign pc_fetch             = pc_q;
  assign instruction_fetchOut = ifid_q.instr;
  assign pc_fetchOut          = ifid_q.pc;
  assign valid_fetchOut       = ifid_q.valid;

endmodule
